uart_frame_ctrl: RTL and testbench
==================================

Name: uart_frame_ctrl

Overview:
- Command sequencer between the UART byte receiver and an internal 8-bit register file.
- Consumes the receiver's byte stream (data plus one-cycle ready pulse) and parses fixed 4-byte frames: SOF, CMD, DATA, CHK.
- Valid write frames update the register file. Valid read frames fetch a register and hand the byte to the UART transmit path over a valid/ready handshake.
- Inter-byte timeout, checksum errors and overrun are detected and flagged.

Parameters:
- ADDR_W, 4, register address width (CMD[ADDR_W-1:0]); ADDR_W <= 7.
- SOF, 8'hA5, start-of-frame byte.
- TIMEOUT, 43400, max idle cycles between bytes inside a frame (10 byte times at 434 clk/bit).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_data  in  8  byte from UART receiver
- rx_ready  in  1  one-cycle pulse, rx_data valid
- reg_we  out  1  register write strobe, one cycle
- reg_re  out  1  register read strobe, one cycle
- reg_addr  out  ADDR_W  register address
- reg_wdata  out  8  write data
- reg_rdata  in  8  read data, valid exactly one cycle after reg_re
- tx_data  out  8  response byte to UART transmitter
- tx_valid  out  1  response valid, held until tx_ready
- tx_ready  in  1  transmitter accepts tx_data
- frame_ok  out  1  one-cycle pulse, frame executed
- frame_err  out  1  one-cycle pulse, error detected
- err_code  out  2  01 timeout, 10 checksum, 11 overrun; holds last error
- busy  out  1  high in every state except IDLE

Behaviour:
- **Reset:**
  - Synchronous, active-high, wins over all inputs.
  - Every output is 0 and state is IDLE.
  - A frame in progress is discarded; any pending response is dropped (tx_valid to 0 next edge).
- **Frame format:**
  - CMD[7] = 1 means read, 0 means write; address is CMD[ADDR_W-1:0]; other bits ignored.
  - DATA is ignored for reads.
  - CHK = CMD ^ DATA.
- **States:** IDLE, GET_CMD, GET_DATA, GET_CHK, EXEC, RD_WAIT, RESP.
  - IDLE: on rx_ready with rx_data==SOF go to GET_CMD. Any other byte is discarded silently, no error.
  - GET_CMD / GET_DATA / GET_CHK: each rx_ready latches the byte and advances. SOF is not special here (no resync).
  - GET_CHK: on rx_ready, a good checksum goes to EXEC. A bad checksum goes to IDLE, with frame_err=1 and err_code=10 on the next cycle.
- **Timeout:**
  - A counter clears on each accepted byte and on entry to GET_CMD; it increments every cycle in the GET_* states.
  - When it reaches TIMEOUT-1 without rx_ready in that cycle: go to IDLE, with frame_err=1 and err_code=01 next cycle.
  - rx_ready in the same cycle as expiry: the byte is accepted and no timeout occurs.
- **Write latency:**
  - CHK byte accepted at edge T.
  - At T+1 (state EXEC): reg_we=1, reg_addr, reg_wdata and frame_ok=1, all for one cycle; then IDLE.
- **Read latency:**
  - At T+1 (EXEC): reg_re=1 and frame_ok=1.
  - At T+2 (RD_WAIT): reg_rdata is captured into tx_data.
  - From T+3 (RESP): tx_valid=1, with tx_data stable until the tx_valid & tx_ready edge; then tx_valid=0 and state IDLE.
  - tx_ready while tx_valid=0 is ignored.
- **Overrun:**
  - Any rx_ready in EXEC, RD_WAIT or RESP drops the byte and pulses frame_err with err_code=11.
  - The current operation continues unaffected.
- **Strobe rules:**
  - reg_we and reg_re are never asserted together.
  - frame_ok and frame_err are never asserted together.
  - reg_addr and reg_wdata hold their last value when not strobed.

Decomposition:
- Shared package uart_pkg:
  - state enum
  - err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_CHKSUM, ERR_OVERRUN)
  - SOF default
  - the 434 bit-period constant, shared with the receiver so TIMEOUT is derived from it
- One natural sub-module, uart_timeout_cnt: clear/enable/expire counter sized $clog2(TIMEOUT).
- FSM, checksum and datapath stay in the top module.

Test Plan:
- **Write frame:** A5 03 3C 3F (bytes 4340 cycles apart) -> reg_we one cycle after CHK byte, reg_addr=3, reg_wdata=3C, frame_ok=1; no tx_valid.
- **Read with backpressure:** A5 85 00 85, reg_rdata=77 on cycle after reg_re, tx_ready low for 10 cycles -> reg_re addr=5; tx_valid=1, tx_data=77 held stable 10 cycles; drops after tx_ready pulse; busy then 0.
- **Checksum error:** A5 03 3C 00 -> frame_err=1, err_code=10, no reg_we. The following A5 03 3C 3F succeeds.
- **Timeout:** A5 03 then silence -> frame_err, err_code=01 exactly TIMEOUT cycles after the 03 byte; state IDLE.
  - Repeat with a byte arriving on the expiry cycle -> no error, frame continues.
- **Noise and overrun:** 12 FF before A5 -> ignored, no error. During RESP with tx_ready low send 55 -> frame_err, err_code=11; tx_data unchanged.
- **Reset mid-frame:** assert rst after A5 03 -> all outputs 0 next edge. Then A5 07 01 06 -> reg_we with addr 7, data 01.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing, frame constants, controller state and error codes.
package uart_pkg;

    localparam int BIT_PERIOD      = 434;
    localparam int BITS_PER_BYTE   = 10;
    // Ten byte times of silence ends a frame.
    localparam int TIMEOUT_DEFAULT = 10 * BITS_PER_BYTE * BIT_PERIOD;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_CHKSUM  = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/uart_timeout_cnt.sv
// Inter-byte idle counter: clears on clr, counts while en, flags the last allowed idle cycle.
module uart_timeout_cnt #(
    parameter int TIMEOUT = 43400
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int          W    = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser and command sequencer between the UART byte stream and the register file.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter int         ADDR_W  = 4,
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic              reg_we,
    output logic              reg_re,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    state_t     state_q, state_d;
    logic [7:0] cmd_q, data_q;
    logic       in_get, in_exec_path, expired, exec_load, err_set;
    logic [1:0] err_val;

    assign in_get       = state_q inside {ST_GET_CMD, ST_GET_DATA, ST_GET_CHK};
    assign in_exec_path = state_q inside {ST_EXEC, ST_RD_WAIT, ST_RESP};

    uart_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rx_ready || state_q == ST_IDLE),
        .en      (in_get),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        exec_load = 1'b0;
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        case (state_q)
            ST_IDLE:     if (rx_ready && rx_data == SOF) state_d = ST_GET_CMD;
            ST_GET_CMD:  if (rx_ready) state_d = ST_GET_DATA;
                         else if (expired) begin state_d = ST_IDLE; err_set = 1'b1; err_val = ERR_TIMEOUT; end
            ST_GET_DATA: if (rx_ready) state_d = ST_GET_CHK;
                         else if (expired) begin state_d = ST_IDLE; err_set = 1'b1; err_val = ERR_TIMEOUT; end
            ST_GET_CHK: begin
                if (rx_ready) begin
                    if (rx_data == (cmd_q ^ data_q)) begin
                        state_d   = ST_EXEC;
                        exec_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        err_set = 1'b1;
                        err_val = ERR_CHKSUM;
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                    err_val = ERR_TIMEOUT;
                end
            end
            ST_EXEC:     state_d = cmd_q[7] ? ST_RD_WAIT : ST_IDLE;
            ST_RD_WAIT:  state_d = ST_RESP;
            ST_RESP:     if (tx_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // Bytes arriving while a command executes are dropped but reported.
        if (rx_ready && in_exec_path) begin
            err_set = 1'b1;
            err_val = ERR_OVERRUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            data_q    <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx_data   <= '0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            if (rx_ready && state_q == ST_GET_CMD)  cmd_q  <= rx_data;
            if (rx_ready && state_q == ST_GET_DATA) data_q <= rx_data;
            // Address and write data only move when a frame is accepted, so they hold between strobes.
            if (exec_load) begin
                reg_addr <= cmd_q[ADDR_W-1:0];
                if (!cmd_q[7]) reg_wdata <= data_q;
            end
            if (state_q == ST_RD_WAIT) tx_data <= reg_rdata;
            frame_err <= err_set;
            if (err_set) err_code <= err_val;
        end
    end

    assign reg_we   = (state_q == ST_EXEC) && !cmd_q[7];
    assign reg_re   = (state_q == ST_EXEC) &&  cmd_q[7];
    assign frame_ok = (state_q == ST_EXEC);
    assign tx_valid = (state_q == ST_RESP);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: cycle vector table, corner sequences, random frames vs model.
module tb_uart_frame_ctrl;

    localparam int TB_TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst, rx_ready, tx_ready, reg_we, reg_re, tx_valid, frame_ok, frame_err, busy;
    logic [7:0] rx_data, reg_wdata, reg_rdata, tx_data;
    logic [3:0] reg_addr;
    logic [1:0] err_code;

    uart_frame_ctrl #(.ADDR_W(4), .SOF(8'hA5), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic       re;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       ok;
        logic       err;
        logic [1:0] code;
        logic       txv;
        logic       busy;
        logic [7:0] txd;
    } out_t;

    typedef struct packed {
        logic       rx_rdy;
        logic [7:0] rx_d;
        logic       tx_rdy;
        out_t       exp;
    } vec_t;

    typedef enum logic [2:0] {EV_NONE, EV_WR, EV_RD, EV_TX, EV_ERR} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] env_mem   [16];
    logic [7:0] model_mem [16];
    logic       pend_re   = 1'b0;
    logic [3:0] pend_addr = 4'h0;
    bit         sb_on     = 1'b0;
    bit         rand_tx   = 1'b0;
    bit         saw_err   = 1'b0;
    ev_t        exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic out_t get_out();
        return {reg_we, reg_re, reg_addr, reg_wdata, frame_ok, frame_err, err_code, tx_valid, busy, tx_data};
    endfunction

    function automatic vec_t mk(input logic rr, input logic [7:0] rd, input logic tr,
                                input logic we, input logic re, input logic [3:0] a, input logic [7:0] wd,
                                input logic ok, input logic err, input logic [1:0] code,
                                input logic txv, input logic bsy, input logic [7:0] txd);
        return {rr, rd, tr, we, re, a, wd, ok, err, code, txv, bsy, txd};
    endfunction

    task automatic sb_event(input ev_t got);
        ev_t want;
        want = {EV_NONE, 4'h0, 8'h00};
        if (exp_q.size() > 0) want = exp_q.pop_front();
        check("scoreboard", 32'(got), 32'(want));
    endtask

    // One clock: register-file model answers reads one cycle late, then outputs are observed.
    task automatic tick();
        @(posedge clk);
        #1;
        reg_rdata = pend_re ? env_mem[pend_addr] : 8'($urandom);
        pend_re   = reg_re;
        pend_addr = reg_addr;
        if (rand_tx) tx_ready = 1'($urandom_range(0, 1));
        if (reg_we) env_mem[reg_addr] = reg_wdata;
        saw_err = saw_err | frame_err;
        if (sb_on) begin
            if (reg_we)               sb_event({EV_WR, reg_addr, reg_wdata});
            if (reg_re)               sb_event({EV_RD, reg_addr, 8'h00});
            if (tx_valid && tx_ready) sb_event({EV_TX, 4'h0, tx_data});
            if (frame_err)            sb_event({EV_ERR, 4'h0, 6'b0, err_code});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick();
        check("wait_idle", 32'(busy), 32'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [21];
        int         first, good, kind;
        logic [7:0] cmd, dat, chk, b;
        logic [3:0] a;

        rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; reg_rdata = 8'h00;
        for (int i = 0; i < 16; i++) env_mem[i] = 8'h40 + 8'(i);
        repeat (3) tick();
        check("reset_outputs", 32'(get_out()), 32'(0));
        rst = 1'b0;

        //            rr  rx     tr  we re a  wdata  ok er cd txv bsy txd
        vecs[0]  = mk(1, 8'h12, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        vecs[1]  = mk(1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        vecs[2]  = mk(1, 8'hA5, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        vecs[3]  = mk(1, 8'h03, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        vecs[4]  = mk(1, 8'h3C, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        vecs[5]  = mk(1, 8'h3F, 0, 1, 0, 3, 8'h3C, 1, 0, 0, 0, 1, 8'h00);
        vecs[6]  = mk(0, 8'h00, 0, 0, 0, 3, 8'h3C, 0, 0, 0, 0, 0, 8'h00);
        vecs[7]  = mk(1, 8'hA5, 0, 0, 0, 3, 8'h3C, 0, 0, 0, 0, 1, 8'h00);
        vecs[8]  = mk(1, 8'h03, 0, 0, 0, 3, 8'h3C, 0, 0, 0, 0, 1, 8'h00);
        vecs[9]  = mk(1, 8'h3C, 0, 0, 0, 3, 8'h3C, 0, 0, 0, 0, 1, 8'h00);
        vecs[10] = mk(1, 8'h00, 0, 0, 0, 3, 8'h3C, 0, 1, 2, 0, 0, 8'h00);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 3, 8'h3C, 0, 0, 2, 0, 0, 8'h00);
        vecs[12] = mk(1, 8'hA5, 0, 0, 0, 3, 8'h3C, 0, 0, 2, 0, 1, 8'h00);
        vecs[13] = mk(1, 8'h81, 0, 0, 0, 3, 8'h3C, 0, 0, 2, 0, 1, 8'h00);
        vecs[14] = mk(1, 8'h11, 0, 0, 0, 3, 8'h3C, 0, 0, 2, 0, 1, 8'h00);
        vecs[15] = mk(1, 8'h90, 0, 0, 1, 1, 8'h3C, 1, 0, 2, 0, 1, 8'h00);
        vecs[16] = mk(0, 8'h00, 0, 0, 0, 1, 8'h3C, 0, 0, 2, 0, 1, 8'h00);
        vecs[17] = mk(0, 8'h00, 0, 0, 0, 1, 8'h3C, 0, 0, 2, 1, 1, 8'h41);
        vecs[18] = mk(1, 8'h55, 0, 0, 0, 1, 8'h3C, 0, 1, 3, 1, 1, 8'h41);
        vecs[19] = mk(0, 8'h00, 1, 0, 0, 1, 8'h3C, 0, 0, 3, 0, 0, 8'h41);
        vecs[20] = mk(0, 8'h00, 1, 0, 0, 1, 8'h3C, 0, 0, 3, 0, 0, 8'h41);

        for (int i = 0; i < 21; i++) begin
            rx_ready = vecs[i].rx_rdy;
            rx_data  = vecs[i].rx_d;
            tx_ready = vecs[i].tx_rdy;
            tick();
            check($sformatf("vec%0d", i), 32'(get_out()), 32'(vecs[i].exp));
        end
        rx_ready = 1'b0;
        tx_ready = 1'b0;

        // Read with ten cycles of transmitter backpressure.
        env_mem[5] = 8'h77;
        send_byte(8'hA5); send_byte(8'h85); send_byte(8'h00); send_byte(8'h85);
        check("rd_strobe", 32'({reg_re, reg_we, reg_addr, frame_ok}), 32'({1'b1, 1'b0, 4'd5, 1'b1}));
        tick();
        good = 0;
        repeat (10) begin
            tick();
            if (tx_valid && tx_data == 8'h77) good++;
        end
        check("rd_hold", 32'(good), 32'(10));
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("rd_release", 32'({tx_valid, busy, tx_data}), 32'({1'b0, 1'b0, 8'h77}));

        // Silence after CMD: error appears exactly TIMEOUT cycles after the CMD byte edge.
        send_byte(8'hA5); send_byte(8'h03);
        first = -1;
        for (int k = 1; k <= TB_TIMEOUT + 5; k++) begin
            tick();
            if (frame_err && first < 0) first = k;
        end
        check("timeout_cycle", 32'(first), 32'(TB_TIMEOUT));
        check("timeout_state", 32'({err_code, busy}), 32'({2'b01, 1'b0}));

        // A byte landing on the expiry cycle is accepted and the frame completes.
        send_byte(8'hA5); send_byte(8'h03);
        saw_err = 1'b0;
        repeat (TB_TIMEOUT - 1) tick();
        send_byte(8'h3C);
        check("expiry_byte_kept", 32'({saw_err, busy}), 32'({1'b0, 1'b1}));
        send_byte(8'h3F);
        check("expiry_frame_done", 32'({reg_we, reg_addr, reg_wdata, saw_err}), 32'({1'b1, 4'd3, 8'h3C, 1'b0}));
        tick();

        // Reset mid-frame clears everything; the next frame runs normally.
        send_byte(8'hA5); send_byte(8'h03);
        rst = 1'b1;
        tick();
        check("reset_midframe", 32'(get_out()), 32'(0));
        rst = 1'b0;
        send_byte(8'hA5); send_byte(8'h07); send_byte(8'h01); send_byte(8'h06);
        check("post_reset_write", 32'({reg_we, reg_re, reg_addr, reg_wdata, frame_ok}),
              32'({1'b1, 1'b0, 4'd7, 8'h01, 1'b1}));
        tick();

        // Random frames against a transaction-level model of the register file.
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 8'($urandom);
            env_mem[i]   = model_mem[i];
        end
        exp_q.delete();
        sb_on   = 1'b1;
        rand_tx = 1'b1;
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b);
                repeat ($urandom_range(0, 5)) tick();
            end
            kind = $urandom_range(0, 99);
            a    = 4'($urandom);
            dat  = 8'($urandom);
            cmd  = {(kind >= 50 && kind < 85), 3'($urandom), a};
            chk  = cmd ^ dat;
            if (kind >= 85) begin
                chk = chk ^ 8'($urandom_range(1, 255));
                exp_q.push_back({EV_ERR, 4'h0, 8'h02});
            end else if (cmd[7]) begin
                exp_q.push_back({EV_RD, a, 8'h00});
                exp_q.push_back({EV_TX, 4'h0, model_mem[a]});
            end else begin
                exp_q.push_back({EV_WR, a, dat});
                model_mem[a] = dat;
            end
            send_byte(8'hA5); repeat ($urandom_range(0, 20)) tick();
            send_byte(cmd);   repeat ($urandom_range(0, 20)) tick();
            send_byte(dat);   repeat ($urandom_range(0, 20)) tick();
            send_byte(chk);
            wait_idle();
        end
        repeat (3) tick();
        sb_on    = 1'b0;
        rand_tx  = 1'b0;
        tx_ready = 1'b0;
        check("sb_drain", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
